// File: rtl/range_window_framer_if.sv
// Sample stream interface for range_window_framer.
// The producer drives in_data/in_valid, the framer drives in_ready.
// A sample transfers on a rising clock edge where in_valid && in_ready.
// in_ready never depends on in_valid. A producer may hold in_valid high
// for as long as it likes. in_data must stay stable while in_valid is
// high and the sample has not yet been accepted.
interface range_window_framer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/range_window_framer.sv
// range_window_framer: cuts a valid/ready sample stream into windows of
// win_len samples. It drives data_out/go/finish to the range-finding stage.
// Window life cycle: IDLE -> RUN -> FIN -> GAP -> IDLE. The shortest
// window period is len + 3 cycles.
// Optional build macro RANGE_FRAMER_TIMEOUT_EN: when it is defined, a RUN
// window that sees TIMEOUT consecutive stall cycles is closed early, and
// the timeout output pulses together with finish.
module range_window_framer #(
    parameter int WIDTH   = 16,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                 clock,
    input  logic                 reset_n,
    range_window_framer_if.slave s_in,
    input  logic                 enable,
    input  logic [LEN_W-1:0]     win_len,
    output logic [WIDTH-1:0]     data_out,
    output logic                 go,
    output logic                 finish,
    output logic                 busy,
    output logic [15:0]          win_count,
    output logic                 timeout,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_len;
    logic [WIDTH-1:0]   r_data;
    logic               r_go;
    logic               r_finish;
    logic [15:0]        r_win_count;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_go_nxt;
    logic               w_finish_nxt;
    logic               w_timeout_hit;

    // in_ready depends only on state, counters, enable and win_len.
    // It is forced low while reset is held, so nothing is accepted mid-reset.
    assign w_in_ready = reset_n &&
                        (((r_state == S_IDLE) && enable && (win_len != '0)) ||
                         ((r_state == S_RUN)  && (r_cnt < r_len)));
    assign s_in.in_ready = w_in_ready;
    assign w_accept      = s_in.in_valid && w_in_ready;

`ifdef RANGE_FRAMER_TIMEOUT_EN
    // The counter only needs to reach TIMEOUT-1; the TIMEOUT-th stall cycle
    // is the one that closes the window.
    localparam int STALL_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [STALL_W-1:0] r_stall;
    logic               r_timeout;

    // Close a RUN window when this cycle is the TIMEOUT-th stall since the
    // last accept. A window that is already full takes the normal finish path.
    assign w_timeout_hit = (r_state == S_RUN) && !w_accept && (r_cnt != r_len) &&
                           (r_stall == STALL_W'(TIMEOUT - 1));

    // Stall counter: clears on any accept (window start included) and counts RUN stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_stall <= '0;
            end else if (r_state == S_RUN) begin
                r_stall <= r_stall + 1'b1;
            end
            r_timeout <= w_finish_nxt && w_timeout_hit;
        end
    end

    assign timeout = r_timeout;
`else
    // With no stall limit, a RUN window waits for samples without bound.
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout_hit    = 1'b0;
    assign timeout          = 1'b0;
`endif

    // State register; an asynchronous reset abandons any open window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: RUN ends on a full window or a stall timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if ((r_cnt == r_len) || w_timeout_hit) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN:   w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: next values of the registered go/finish strobes.
    always_comb begin
        w_go_nxt     = 1'b0;
        w_finish_nxt = 1'b0;
        if ((r_state == S_IDLE) && w_accept) begin
            w_go_nxt = 1'b1;
        end
        if ((r_state == S_RUN) && (w_state_nxt == S_FIN)) begin
            w_finish_nxt = 1'b1;
        end
    end

    // Datapath: capture samples, latch the window length, count windows.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data      <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_go        <= 1'b0;
            r_finish    <= 1'b0;
            r_win_count <= '0;
        end else begin
            r_go     <= w_go_nxt;
            r_finish <= w_finish_nxt;
            if (w_accept) begin
                r_data <= s_in.in_data;
            end
            if ((r_state == S_IDLE) && w_accept) begin
                r_len <= win_len;
                r_cnt <= {{(LEN_W-1){1'b0}}, 1'b1};
            end else if ((r_state == S_RUN) && w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_FIN) begin
                r_win_count <= r_win_count + 16'd1;
            end
        end
    end

    assign data_out  = r_data;
    assign go        = r_go;
    assign finish    = r_finish;
    assign busy      = (r_state != S_IDLE);
    assign win_count = r_win_count;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_range_window_framer.sv
// Directed testbench for range_window_framer.
// Accepted samples go into a scoreboard queue, and each one is checked on
// data_out in the cycle after it is accepted. A monitor checks the go/finish
// protocol on every cycle.
module tb_range_window_framer;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [7:0]  win_len;
  logic [15:0] data_out;
  logic        go;
  logic        finish;
  logic        busy;
  logic [15:0] win_count;
  logic        timeout;
  logic [1:0]  dbg_state;

  range_window_framer_if #(.WIDTH(16)) bif ();

  range_window_framer #(.WIDTH(16), .LEN_W(8), .TIMEOUT(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .s_in      (bif),
    .enable    (enable),
    .win_len   (win_len),
    .data_out  (data_out),
    .go        (go),
    .finish    (finish),
    .busy      (busy),
    .win_count (win_count),
    .timeout   (timeout),
    .dbg_state (dbg_state)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [15:0] exp_q[$];
  int          go_q[$];
  int          fin_q[$];
  int          cyc           = 0;
  int          last_data_cyc = 0;
  logic [15:0] go_data       = '0;
  logic [15:0] fin_data      = '0;
  logic        fin_to        = 1'b0;
  logic        pend          = 1'b0;
  logic        open_win      = 1'b0;
  logic [1:0]  prev_state    = 2'd0;
  int          exp_wc        = 0;

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // monitor: scoreboard pop and per-cycle protocol invariants
  always @(negedge clock) begin
    cyc++;
    if (!reset_n) begin
      pend     = 1'b0;
      open_win = 1'b0;
      exp_q.delete();
    end else begin
      if (pend) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("sb_data", {16'd0, data_out}, {16'd0, exp_q.pop_front()});
        last_data_cyc = cyc;
      end
      chk("inv_go_finish_excl", {31'd0, go && finish}, 32'd0);
      chk("inv_timeout_alone", {31'd0, timeout && !finish}, 32'd0);
      if (go) begin
        chk("inv_go_from_idle", {30'd0, prev_state}, 32'd0);
        chk("inv_go_window_closed", {31'd0, open_win}, 32'd0);
        open_win = 1'b1;
        go_data  = data_out;
        go_q.push_back(cyc);
      end
      if (finish) begin
        chk("inv_finish_after_go", {31'd0, open_win}, 32'd1);
        open_win = 1'b0;
        fin_data = data_out;
        fin_to   = timeout;
        fin_q.push_back(cyc);
      end
      pend = bif.in_valid && bif.in_ready;
    end
    prev_state = dbg_state;
  end

  // driver tasks (always entered and left at posedge + 1)
  task automatic send(input logic [15:0] d);
    int k;
    bif.in_data  = d;
    bif.in_valid = 1'b1;
    k = 0;
    @(negedge clock);
    while (!bif.in_ready && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk("send_ready", {31'd0, bif.in_ready}, 32'd1);
    if (bif.in_ready) exp_q.push_back(d);
    else bif.in_valid = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_fin(input string tag);
    int k;
    k = 0;
    @(negedge clock);
    while (!finish && k < 60) begin
      @(negedge clock);
      k++;
    end
    chk({tag, "_finish_seen"}, {31'd0, finish}, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    @(negedge clock);
    while (busy && k < 60) begin
      @(negedge clock);
      k++;
    end
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    @(posedge clock);
    #1;
  endtask

  // directed sequence
  initial begin
    int n_go;
    int n_fin;
    int rdy_seen;

    reset_n      = 1'b0;
    enable       = 1'b1;
    win_len      = 8'd4;
    bif.in_valid = 1'b0;
    bif.in_data  = '0;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_data_out", {16'd0, data_out}, 32'd0);
    chk("rst_go", {31'd0, go}, 32'd0);
    chk("rst_finish", {31'd0, finish}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_win_count", {16'd0, win_count}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_in_ready", {31'd0, bif.in_ready}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // basic window 5,9,2,7
    go_q.delete();
    fin_q.delete();
    send(16'd5);
    send(16'd9);
    send(16'd2);
    send(16'd7);
    bif.in_valid = 1'b0;
    wait_fin("basic");
    exp_wc++;
    @(negedge clock);
    chk("basic_gap_in_ready", {31'd0, bif.in_ready}, 32'd0);
    chk("basic_gap_busy", {31'd0, busy}, 32'd1);
    chk("basic_win_count", {16'd0, win_count}, 32'(exp_wc));
    chk("basic_go_data", {16'd0, go_data}, 32'd5);
    chk("basic_fin_data", {16'd0, fin_data}, 32'd7);
    chk("basic_fin_timeout", {31'd0, fin_to}, 32'd0);
    if (go_q.size() == 1 && fin_q.size() == 1)
      chk("basic_go_to_finish", 32'(fin_q[0] - go_q[0]), 32'd4);
    else chk("basic_strobe_count", 32'(go_q.size() * 16 + fin_q.size()), 32'h11);
    @(negedge clock);
    chk("basic_idle_busy", {31'd0, busy}, 32'd0);
    chk("basic_idle_in_ready", {31'd0, bif.in_ready}, 32'd1);
    @(posedge clock);
    #1;

    // stalled input
    win_len = 8'd3;
    send(16'd10);
    bif.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("stall_hold_data", {16'd0, data_out}, 32'd10);
      chk("stall_busy", {31'd0, busy}, 32'd1);
      chk("stall_no_finish", {31'd0, finish}, 32'd0);
      @(posedge clock);
      #1;
    end
    send(16'd20);
    send(16'd30);
    bif.in_valid = 1'b0;
    wait_fin("stall");
    exp_wc++;
    @(posedge clock);
    #1;
    chk("stall_fin_data", {16'd0, fin_data}, 32'd30);
    chk("stall_fin_latency", 32'(fin_q[fin_q.size()-1] - last_data_cyc), 32'd1);
    wait_idle("stall");
    chk("stall_win_count", {16'd0, win_count}, 32'(exp_wc));

    // edge length 1
    win_len = 8'd1;
    send(16'hFFFF);
    bif.in_valid = 1'b0;
    wait_fin("len1");
    exp_wc++;
    @(posedge clock);
    #1;
    chk("len1_go_data", {16'd0, go_data}, 32'hFFFF);
    chk("len1_fin_data", {16'd0, fin_data}, 32'hFFFF);
    chk("len1_go_to_finish", 32'(fin_q[fin_q.size()-1] - go_q[go_q.size()-1]), 32'd1);
    wait_idle("len1");
    chk("len1_win_count", {16'd0, win_count}, 32'(exp_wc));

    // edge length 0: nothing may start
    win_len      = 8'd0;
    bif.in_data  = 16'h1234;
    bif.in_valid = 1'b1;
    n_go         = go_q.size();
    rdy_seen     = 0;
    repeat (20) begin
      @(negedge clock);
      if (bif.in_ready) rdy_seen++;
    end
    bif.in_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("len0_ready_cycles", 32'(rdy_seen), 32'd0);
    chk("len0_go_count", 32'(go_q.size()), 32'(n_go));
    chk("len0_busy", {31'd0, busy}, 32'd0);

    // back-to-back windows of 2, with win_len disturbed mid-window
    win_len = 8'd2;
    go_q.delete();
    fin_q.delete();
    for (int i = 0; i < 8; i++) begin
      send(16'(16'h0100 + i * 3));
      if (i == 0) win_len = 8'd7;
      if (i == 1) win_len = 8'd2;
    end
    bif.in_valid = 1'b0;
    wait_fin("b2b");
    wait_idle("b2b");
    exp_wc += 4;
    chk("b2b_go_count", 32'(go_q.size()), 32'd4);
    chk("b2b_fin_count", 32'(fin_q.size()), 32'd4);
    if (go_q.size() == 4 && fin_q.size() == 4) begin
      for (int i = 0; i < 3; i++) chk("b2b_period", 32'(go_q[i+1] - go_q[i]), 32'd5);
      for (int i = 0; i < 4; i++) chk("b2b_len", 32'(fin_q[i] - go_q[i]), 32'd2);
    end
    chk("b2b_win_count", {16'd0, win_count}, 32'(exp_wc));

    // reset in the middle of a window
    win_len = 8'd5;
    send(16'h0011);
    send(16'h0022);
    #2;
    bif.in_valid = 1'b0;
    reset_n      = 1'b0;
    #1;
    chk("midrst_go", {31'd0, go}, 32'd0);
    chk("midrst_finish", {31'd0, finish}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_data_out", {16'd0, data_out}, 32'd0);
    chk("midrst_in_ready", {31'd0, bif.in_ready}, 32'd0);
    chk("midrst_win_count", {16'd0, win_count}, 32'd0);
    exp_wc = 0;
    n_fin  = fin_q.size();
    n_go   = go_q.size();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("midrst_no_finish", 32'(fin_q.size()), 32'(n_fin));
    win_len = 8'd2;
    send(16'h0033);
    send(16'h0044);
    bif.in_valid = 1'b0;
    wait_fin("postrst");
    exp_wc++;
    wait_idle("postrst");
    chk("postrst_go_seen", 32'(go_q.size()), 32'(n_go + 1));
    chk("postrst_fin_data", {16'd0, fin_data}, 32'h0044);
    chk("postrst_win_count", {16'd0, win_count}, 32'(exp_wc));

    // stall timeout
    win_len = 8'd4;
    send(16'h0AAA);
    send(16'h0BBB);
    bif.in_valid = 1'b0;
`ifdef RANGE_FRAMER_TIMEOUT_EN
    wait_fin("tmo");
    exp_wc++;
    @(posedge clock);
    #1;
    chk("tmo_timeout_with_finish", {31'd0, fin_to}, 32'd1);
    chk("tmo_latency", 32'(fin_q[fin_q.size()-1] - last_data_cyc), 32'd8);
    chk("tmo_fin_data", {16'd0, fin_data}, 32'h0BBB);
    wait_idle("tmo");
    chk("tmo_win_count", {16'd0, win_count}, 32'(exp_wc));
`else
    n_fin = fin_q.size();
    repeat (40) @(posedge clock);
    #1;
    chk("notmo_no_finish", 32'(fin_q.size()), 32'(n_fin));
    chk("notmo_still_busy", {31'd0, busy}, 32'd1);
    chk("notmo_timeout_low", {31'd0, timeout}, 32'd0);
    send(16'h0CCC);
    send(16'h0DDD);
    bif.in_valid = 1'b0;
    wait_fin("notmo");
    exp_wc++;
    wait_idle("notmo");
    chk("notmo_fin_data", {16'd0, fin_data}, 32'h0DDD);
    chk("notmo_win_count", {16'd0, win_count}, 32'(exp_wc));
`endif
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/range_window_framer.md
Name: range_window_framer

Overview:
- Upstream sequencer for the range-finding stage.
- Accepts a valid/ready sample stream and slices it into windows of programmable length.
- Drives the downstream stage's sample, start and end strobes (data_out, go, finish) with legal protocol timing: go and finish never coincide, and no go is issued while a window is open.
- Holds the last sample on data_out during input stalls; repeating a sample cannot change a max/min result.

Parameters:
- WIDTH, 16, sample width.
- LEN_W, 8, width of the window-length input.
- TIMEOUT, 64, stall-cycle limit used only when the optional feature is compiled in.

Ports:
- clock  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  sample.
- in_valid  input  1  sample valid.
- in_ready  output  1  framer accepts the sample this cycle.
- enable  input  1  permits a new window to start.
- win_len  input  LEN_W  samples per window; sampled when a window starts.
- data_out  output  WIDTH  sample to the downstream stage (registered).
- go  output  1  one-cycle window-start strobe (registered).
- finish  output  1  one-cycle window-end strobe (registered).
- busy  output  1  window open (state != IDLE).
- win_count  output  16  completed windows, wraps 0xFFFF -> 0x0000.
- timeout  output  1  one-cycle pulse on a timed-out window; tied 0 when the feature is absent.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE.
  - data_out = 0, go = 0, finish = 0, busy = 0, win_count = 0, timeout = 0.
  - in_ready = 0 while reset_n is low.
  - Reset mid-window aborts the window immediately; no finish is issued.
- Accept rule: a transfer occurs on a rising edge with in_valid && in_ready.
- in_ready is combinational from state, cnt, len and enable only, never from in_valid.
- States are IDLE, RUN, FIN and GAP.
- IDLE:
  - in_ready = enable && (win_len != 0).
  - On accept: data_out <= in_data, go <= 1, len <= win_len, cnt <= 1, next state RUN.
  - win_len == 0 means no windows start and in_ready stays 0.
- RUN:
  - go <= 0 (go is high exactly one cycle, aligned with the first sample on data_out).
  - in_ready = (cnt < len).
  - On accept: data_out <= in_data, cnt <= cnt + 1.
  - No accept: data_out holds its value.
  - When cnt == len at a clock edge: finish <= 1, next state FIN.
  - Consequence: the last sample is presented for at least one cycle before finish.
  - len == 1: go cycle, then finish on the next cycle.
- FIN:
  - finish is high for this single cycle; in_ready = 0; data_out holds the last sample.
  - On exit: finish <= 0, win_count <= win_count + 1, next state GAP.
- GAP:
  - One dead cycle so the downstream result register settles; in_ready = 0.
  - Next state IDLE.
- Minimum window period is len + 3 cycles.
- Widths:
  - cnt is LEN_W bits; it cannot overflow because it stops at len <= 2^LEN_W - 1.
  - win_len changes during a window are ignored.
- enable:
  - enable only gates window start.
  - Deasserting enable mid-window does not stop the window; it completes normally.
- Invariants the bench checks every cycle:
  - !(go && finish).
  - go only while state was IDLE.
  - finish only preceded by a go with no intervening finish.

Optional Feature:
- Macro: RANGE_FRAMER_TIMEOUT_EN.
- Defined:
  - A stall counter clears on every accept and on window start.
  - It increments on each RUN cycle without an accept.
  - On reaching TIMEOUT, the block forces the FIN transition: finish <= 1 and timeout <= 1 for the same single cycle.
  - win_count still increments; the truncated window is treated as complete.
- Undefined:
  - No stall counter; a window in RUN waits indefinitely for samples.
  - timeout is tied 0 and TIMEOUT is unused.

Test Plan:
- Basic window: reset, enable=1, win_len=4, stream 5,9,2,7 with in_valid held high
  - go high with data_out=5.
  - data_out steps 9, 2, 7.
  - finish high one cycle later with data_out=7.
  - win_count = 1; GAP cycle has in_ready = 0.
- Stalled input: win_len=3, samples 10, (4 idle cycles), 20, 30
  - data_out holds 10 during the stall.
  - No finish until one cycle after 30 appears.
  - busy high throughout.
- Edge lengths:
  - win_len=1, sample 0xFFFF: go cycle, then finish on the next cycle, never simultaneous.
  - win_len=0: in_ready stays 0 for 20 cycles, go never asserts.
- Back-to-back windows: win_len=2, continuous valid stream of 8 samples
  - 4 windows, each len + 3 = 5 cycles apart.
  - win_count = 4; win_len changed mid-window has no effect until the next go.
- Reset mid-window: win_len=5, assert reset_n=0 after 2 samples
  - go, finish, busy and data_out go to 0 immediately, without waiting for a clock edge.
  - After release, the next window starts cleanly with go.
- Timeout (macro defined, TIMEOUT=8): win_len=4, 2 samples then in_valid=0
  - finish and timeout high together exactly 8 stall cycles after the last accept.
  - win_count = 1.
  - With the macro undefined, no finish occurs.
